// File: rtl/vector_mem_sequencer_if.sv
// Single-port memory bus shared by instruction fetch and data accesses.
// The sequencer is the master; the memory (or its arbiter) is the slave.
interface vector_mem_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_wen,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_wen,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Load/store sequencer behind the SIMD datapath. Fetches one instruction,
// gives the datapath a cycle to decode it, then performs either one scalar
// access or THREADS per-lane accesses (lane 0 first) on the single memory
// bus. Completion is a one-cycle iHit (plus dHit when memory was touched).
module vector_mem_sequencer #(
    parameter int unsigned THREADS = 4,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                           CLK,
    input  logic                           nRST,

    // instruction side
    input  logic [ADDR_W-1:0]              iaddr,
    input  logic                           instReq,
    output logic [ADDR_W-1:0]              iload,
    output logic                           iHit,

    // data side
    input  logic                           readReq,
    input  logic                           writeReq,
    input  logic                           isVector,
    input  logic [ADDR_W-1:0]              sdaddr,
    input  logic [ADDR_W-1:0]              sdstore,
    output logic [ADDR_W-1:0]              sdload,
    input  logic [THREADS-1:0][ADDR_W-1:0] vdaddr,
    input  logic [THREADS-1:0][ADDR_W-1:0] vdstore,
    output logic [THREADS-1:0][ADDR_W-1:0] vdload,
    output logic                           dHit,
    input  logic                           dhalt,

    // memory bus
    vector_mem_sequencer_if.master         mem,

    output logic                           halted
);
    localparam int unsigned       LANE_W    = $clog2(THREADS);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(THREADS - 1);

    typedef enum logic [2:0] {
        IFETCH,
        DCHECK,
        DACCESS,
        DONE,
        HALTED
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] next_lane;
    logic              did_access;
    logic              next_did_access;

    logic              req_c;
    logic              wen_c;
    logic [ADDR_W-1:0] addr_c;
    logic [ADDR_W-1:0] wdata_c;
    logic              capture_inst;
    logic              capture_sd;
    logic              capture_vd;

    // State, active lane and "memory was touched" flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IFETCH;
            lane       <= '0;
            did_access <= 1'b0;
        end else begin
            state      <= next_state;
            lane       <= next_lane;
            did_access <= next_did_access;
        end
    end

    // Next state, bus drive, capture enables and commit strobes
    always_comb begin
        next_state      = state;
        next_lane       = lane;
        next_did_access = did_access;
        req_c           = 1'b0;
        wen_c           = 1'b0;
        addr_c          = '0;
        wdata_c         = '0;
        capture_inst    = 1'b0;
        capture_sd      = 1'b0;
        capture_vd      = 1'b0;
        iHit            = 1'b0;
        dHit            = 1'b0;
        halted          = 1'b0;

        unique case (state)
            IFETCH: begin
                addr_c = iaddr;
                if (dhalt) begin
                    // halt wins over a pending fetch; nothing is issued
                    next_state = HALTED;
                end else begin
                    req_c = instReq;
                    if (instReq && mem.mem_ready) begin
                        capture_inst = 1'b1;
                        next_state   = DCHECK;
                    end
                end
            end

            DCHECK: begin
                next_lane = '0;
                if (readReq || writeReq) begin
                    next_did_access = 1'b1;
                    next_state      = DACCESS;
                end else begin
                    next_did_access = 1'b0;
                    next_state      = DONE;
                end
            end

            DACCESS: begin
                // a simultaneous read and write request is issued as a write
                req_c   = 1'b1;
                wen_c   = writeReq;
                addr_c  = isVector ? vdaddr[lane]  : sdaddr;
                wdata_c = isVector ? vdstore[lane] : sdstore;
                if (mem.mem_ready) begin
                    capture_sd = !writeReq && !isVector;
                    capture_vd = !writeReq && isVector;
                    if (!isVector || (lane == LAST_LANE)) begin
                        next_state = DONE;
                    end else begin
                        next_lane = lane + 1'b1;
                    end
                end
            end

            DONE: begin
                iHit       = 1'b1;
                dHit       = did_access;
                next_state = IFETCH;
            end

            HALTED: begin
                halted = 1'b1;
            end

            default: begin
                next_state = IFETCH;
            end
        endcase
    end

    // Request is gated by nRST so the bus goes idle the moment reset asserts
    assign mem.mem_req   = req_c & nRST;
    assign mem.mem_wen   = wen_c & nRST;
    assign mem.mem_addr  = addr_c & ~ADDR_W'(3);
    assign mem.mem_wdata = wdata_c;

    // Fetched instruction and load data; each holds until its next capture
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iload  <= '0;
            sdload <= '0;
            vdload <= '0;
        end else begin
            if (capture_inst) begin
                iload <= mem.mem_rdata;
            end
            if (capture_sd) begin
                sdload <= mem.mem_rdata;
            end
            if (capture_vd) begin
                vdload[lane] <= mem.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: a table of instructions run
// through a scripted memory responder with a request scoreboard, plus
// hand-written reset-mid-vector and halt sequences.
module tb_vector_mem_sequencer;
    localparam int unsigned THREADS = 4;
    localparam int unsigned AW      = 32;

    logic                       CLK = 1'b0;
    logic                       nRST = 1'b0;
    logic [31:0]                iaddr = '0;
    logic                       instReq = 1'b0;
    logic [31:0]                iload;
    logic                       iHit;
    logic                       readReq = 1'b0;
    logic                       writeReq = 1'b0;
    logic                       isVector = 1'b0;
    logic [31:0]                sdaddr = '0;
    logic [31:0]                sdstore = '0;
    logic [31:0]                sdload;
    logic [THREADS-1:0][31:0]   vdaddr = '0;
    logic [THREADS-1:0][31:0]   vdstore = '0;
    logic [THREADS-1:0][31:0]   vdload;
    logic                       dHit;
    logic                       dhalt = 1'b0;
    logic                       halted;

    vector_mem_sequencer_if #(.ADDR_W(AW)) bus ();

    vector_mem_sequencer #(.THREADS(THREADS), .ADDR_W(AW)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iaddr    (iaddr),
        .instReq  (instReq),
        .iload    (iload),
        .iHit     (iHit),
        .readReq  (readReq),
        .writeReq (writeReq),
        .isVector (isVector),
        .sdaddr   (sdaddr),
        .sdstore  (sdstore),
        .sdload   (sdload),
        .vdaddr   (vdaddr),
        .vdstore  (vdstore),
        .vdload   (vdload),
        .dHit     (dHit),
        .dhalt    (dhalt),
        .mem      (bus.master),
        .halted   (halted)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned waits;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        int unsigned fetch_wait;
        logic        rd;
        logic        wr;
        logic        vec;
        logic [31:0] saddr;
        logic [31:0] sstore;
        logic [31:0] vbase;
        logic [31:0] rbase;
        int unsigned wait_lane;
        int unsigned wait_n;
        int unsigned exp_lat;
        logic        exp_dhit;
    } vec_t;

    resp_t stim_q[$];
    req_t  exp_q[$];
    vec_t  tbl[$];

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    logic [31:0]              exp_iload  = '0;
    logic [31:0]              exp_sdload = '0;
    logic [THREADS-1:0][31:0] exp_vdload = '0;

    function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void check1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(string name, logic [31:0] pc, logic [31:0] instr,
                                int unsigned fw, logic rd, logic wr, logic vec,
                                logic [31:0] saddr, logic [31:0] sstore,
                                logic [31:0] vbase, logic [31:0] rbase,
                                int unsigned wl, int unsigned wn,
                                int unsigned lat, logic dh);
        vec_t v;
        v.name = name;   v.pc = pc;         v.instr = instr;   v.fetch_wait = fw;
        v.rd = rd;       v.wr = wr;         v.vec = vec;
        v.saddr = saddr; v.sstore = sstore; v.vbase = vbase;   v.rbase = rbase;
        v.wait_lane = wl; v.wait_n = wn;    v.exp_lat = lat;   v.exp_dhit = dh;
        return v;
    endfunction

    // Memory responder: scripted wait states, stability and scoreboard checks
    resp_t       cur;
    req_t        snap;
    req_t        e;
    int unsigned held = 0;
    logic        pending = 1'b0;

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge CLK);
            #2;
            bus.mem_ready = 1'b0;
            if (bus.mem_req !== 1'b1) begin
                pending = 1'b0;
            end else begin
                if (!pending) begin
                    pending = 1'b1;
                    held    = 0;
                    if (stim_q.size() > 0) begin
                        cur = stim_q.pop_front();
                    end else begin
                        cur.waits = 0;
                        cur.rdata = '0;
                    end
                    snap.wen   = bus.mem_wen;
                    snap.addr  = bus.mem_addr;
                    snap.wdata = bus.mem_wdata;
                end else begin
                    held++;
                    check32("hold_addr", bus.mem_addr, snap.addr);
                    check1("hold_wen", bus.mem_wen, snap.wen);
                    if (snap.wen) check32("hold_wdata", bus.mem_wdata, snap.wdata);
                end
                if (held == cur.waits) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = cur.rdata;
                    pending       = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL unexpected_req: got request addr 0x%08h wen %b, expected none",
                                 snap.addr, snap.wen);
                    end else begin
                        e = exp_q.pop_front();
                        check1("req_wen", snap.wen, e.wen);
                        check32("req_addr", snap.addr, e.addr);
                        if (e.wen) check32("req_wdata", snap.wdata, e.wdata);
                    end
                end
            end
        end
    end

    task automatic check_outputs(string tag);
        check32({tag, ".iload"}, iload, exp_iload);
        check32({tag, ".sdload"}, sdload, exp_sdload);
        for (int l = 0; l < int'(THREADS); l++) begin
            check32($sformatf("%s.vdload%0d", tag, l), vdload[l], exp_vdload[l]);
        end
    endtask

    task automatic recover();
        instReq  = 1'b0;
        nRST     = 1'b0;
        stim_q.delete();
        exp_q.delete();
        exp_iload  = '0;
        exp_sdload = '0;
        exp_vdload = '0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Drive one instruction at a falling edge and check its commit
    task automatic run_entry(input vec_t v);
        int unsigned n;
        int unsigned lat;
        resp_t       r;
        req_t        q;

        @(negedge CLK);
        iaddr    = v.pc;
        readReq  = v.rd;
        writeReq = v.wr;
        isVector = v.vec;
        sdaddr   = v.saddr;
        sdstore  = v.sstore;
        for (int l = 0; l < int'(THREADS); l++) begin
            vdaddr[l]  = v.vbase + 32'(l * 16);
            vdstore[l] = 32'(l + 1);
        end

        r.waits = v.fetch_wait; r.rdata = v.instr;
        stim_q.push_back(r);
        q.wen = 1'b0; q.addr = v.pc & 32'hFFFF_FFFC; q.wdata = '0;
        exp_q.push_back(q);
        if (v.rd || v.wr) begin
            n = v.vec ? THREADS : 1;
            for (int l = 0; l < int'(n); l++) begin
                r.waits = (l == int'(v.wait_lane)) ? v.wait_n : 0;
                r.rdata = v.rbase + 32'(l);
                stim_q.push_back(r);
                q.wen   = v.wr;
                q.addr  = (v.vec ? v.vbase + 32'(l * 16) : v.saddr) & 32'hFFFF_FFFC;
                q.wdata = v.vec ? 32'(l + 1) : v.sstore;
                exp_q.push_back(q);
            end
        end
        instReq = 1'b1;

        #3;
        lat = 1;
        while (iHit !== 1'b1 && lat < 60) begin
            @(negedge CLK);
            #3;
            lat++;
        end

        if (iHit !== 1'b1) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s.timeout: got no iHit within %0d cycles, expected at cycle %0d",
                     v.name, lat, v.exp_lat);
            recover();
            return;
        end

        exp_iload = v.instr;
        if (v.rd && !v.wr) begin
            if (v.vec) begin
                for (int l = 0; l < int'(THREADS); l++) exp_vdload[l] = v.rbase + 32'(l);
            end else begin
                exp_sdload = v.rbase;
            end
        end

        check32({v.name, ".latency"}, lat, v.exp_lat);
        check1({v.name, ".dHit"}, dHit, v.exp_dhit);
        check1({v.name, ".done_mem_req"}, bus.mem_req, 1'b0);
        check_outputs(v.name);

        instReq  = 1'b0;
        readReq  = 1'b0;
        writeReq = 1'b0;
        @(negedge CLK);
        #3;
        check1({v.name, ".iHit_pulse"}, iHit, 1'b0);
        check1({v.name, ".dHit_pulse"}, dHit, 1'b0);
        check32({v.name, ".sb_left"}, exp_q.size(), 0);
    endtask

    int unsigned guard;
    vec_t        rv;

    initial begin
        //            name          pc         instr        fw rd    wr    vec   saddr      sstore        vbase      rbase         wl wn lat dh
        tbl.push_back(mk("nomem",   32'h00, 32'h20010005, 0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,   32'h0,        0, 0, 3,  1'b0));
        tbl.push_back(mk("sload",   32'h04, 32'h8C220000, 0, 1'b1, 1'b0, 1'b0, 32'h103, 32'h0,        32'h0,   32'hDEADBEEF, 0, 2, 6,  1'b1));
        tbl.push_back(mk("vstore",  32'h08, 32'hAC000000, 0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h0,        32'h10,  32'h0,        0, 0, 7,  1'b1));
        tbl.push_back(mk("vload",   32'h0C, 32'h8C000001, 0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h0,        32'h101, 32'hA0,       2, 3, 10, 1'b1));
        tbl.push_back(mk("sstore",  32'h1E, 32'hAC120000, 1, 1'b0, 1'b1, 1'b0, 32'h207, 32'h12345678, 32'h0,   32'h0,        0, 0, 5,  1'b1));
        tbl.push_back(mk("rdwr",    32'h20, 32'h8C330000, 0, 1'b1, 1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0,   32'h55555555, 0, 1, 5,  1'b1));
        tbl.push_back(mk("nomem_w", 32'h24, 32'h00000020, 2, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,   32'h0,        0, 0, 5,  1'b0));
        tbl.push_back(mk("vload2",  32'h28, 32'h8C000002, 0, 1'b1, 1'b0, 1'b1, 32'h0,   32'h0,        32'h203, 32'hB0,       0, 0, 7,  1'b1));
        tbl.push_back(mk("sload0",  32'h2C, 32'h8C440000, 0, 1'b1, 1'b0, 1'b0, 32'h404, 32'h0,        32'h0,   32'h0BADF00D, 0, 0, 4,  1'b1));

        // reset state
        #1;
        check1("rst.iHit", iHit, 1'b0);
        check1("rst.dHit", dHit, 1'b0);
        check1("rst.halted", halted, 1'b0);
        check1("rst.mem_req", bus.mem_req, 1'b0);
        check1("rst.mem_wen", bus.mem_wen, 1'b0);
        check_outputs("rst");
        @(negedge CLK);
        nRST = 1'b1;

        foreach (tbl[i]) run_entry(tbl[i]);

        // reset while lane 1 of a vector load is waiting on memory
        rv = mk("rstvec", 32'h30, 32'h8C000003, 0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0,
                32'h600, 32'hC0, 1, 8, 0, 1'b1);
        @(negedge CLK);
        iaddr = rv.pc; readReq = 1'b1; writeReq = 1'b0; isVector = 1'b1;
        for (int l = 0; l < int'(THREADS); l++) vdaddr[l] = rv.vbase + 32'(l * 16);
        begin
            resp_t r;
            req_t  q;
            r.waits = 0; r.rdata = rv.instr;      stim_q.push_back(r);
            q.wen = 1'b0; q.addr = rv.pc; q.wdata = '0; exp_q.push_back(q);
            r.waits = 0; r.rdata = 32'hC0;        stim_q.push_back(r);
            q.addr = 32'h600;                     exp_q.push_back(q);
            r.waits = 8; r.rdata = 32'hC1;        stim_q.push_back(r);
        end
        instReq = 1'b1;
        #3;
        guard = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr === 32'h610) && guard < 20) begin
            @(negedge CLK);
            #3;
            guard++;
        end
        check1("rstvec.reached_lane1", bus.mem_addr === 32'h610, 1'b1);
        nRST    = 1'b0;
        instReq = 1'b0;
        readReq = 1'b0;
        isVector = 1'b0;
        #1;
        stim_q.delete();
        exp_q.delete();
        exp_iload  = '0;
        exp_sdload = '0;
        exp_vdload = '0;
        check1("rstvec.iHit", iHit, 1'b0);
        check1("rstvec.dHit", dHit, 1'b0);
        check1("rstvec.mem_req", bus.mem_req, 1'b0);
        check1("rstvec.mem_wen", bus.mem_wen, 1'b0);
        check1("rstvec.halted", halted, 1'b0);
        check_outputs("rstvec");
        @(negedge CLK);
        nRST = 1'b1;
        run_entry(mk("after_rst", 32'h40, 32'h11112222, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                     32'h0, 32'h0, 0, 0, 3, 1'b0));

        // halt right after a commit; sticky even once dhalt drops
        @(negedge CLK);
        dhalt   = 1'b1;
        instReq = 1'b1;
        iaddr   = 32'h80;
        #3;
        check1("halt.first_mem_req", bus.mem_req, 1'b0);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (c == 3) dhalt = 1'b0;
            #3;
            check1($sformatf("halt.halted%0d", c), halted, 1'b1);
            check1($sformatf("halt.mem_req%0d", c), bus.mem_req, 1'b0);
            check1($sformatf("halt.iHit%0d", c), iHit, 1'b0);
        end
        check_outputs("halt");
        instReq = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Sits directly downstream of the SIMD datapath on its load/store interface; owns the single-port memory bus.
- Fetches each instruction, then runs that instruction's data access: one scalar access, or THREADS lane accesses serialised in order (lane 0 first).
- Holds the fetched instruction and the loaded data stable in registers.
- Signals completion with a one-cycle iHit/dHit commit strobe; the datapath advances the PC only on that strobe.

Parameters:
- THREADS, 4, vector lane count; must be ≥2 and a power of two.
- ADDR_W, 32, address/data width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- iaddr  in  32  instruction address (PC).
- instReq  in  1  instruction fetch enable.
- iload  out  32  registered fetched instruction.
- iHit  out  1  instruction commit strobe.
- readReq  in  1  data load request (decoded from iload).
- writeReq  in  1  data store request (decoded from iload).
- isVector  in  1  access is per-lane.
- sdaddr  in  32  scalar data address.
- sdstore  in  32  scalar store data.
- sdload  out  32  registered scalar load data.
- vdaddr  in  THREADSx32  per-lane addresses.
- vdstore  in  THREADSx32  per-lane store data.
- vdload  out  THREADSx32  registered per-lane load data.
- dHit  out  1  data commit strobe.
- dhalt  in  1  halt request from the datapath.
- mem_req  out  1  memory request.
- mem_wen  out  1  1 = write, 0 = read.
- mem_addr  out  32  word address; bits [1:0] forced to 0.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid with mem_ready.
- mem_ready  in  1  one-cycle completion for the current request.
- halted  out  1  sequencer is parked.

Behaviour:
- States: IFETCH, DCHECK, DACCESS, DONE, HALTED. A lane counter of $clog2(THREADS) bits selects the active lane.
- Reset (async):
  - State = IFETCH; lane = 0.
  - iload, sdload, all vdload = 0.
  - iHit, dHit, mem_req, mem_wen, halted = 0.
  - Reset mid-access abandons the access with no commit; the memory side must tolerate a dropped request.
- IFETCH:
  - mem_req = instReq & !dhalt; mem_wen = 0; mem_addr = iaddr.
  - On an edge with mem_req & mem_ready: iload <= mem_rdata, go to DCHECK.
  - If dhalt = 1, go to HALTED without issuing a request.
- DCHECK:
  - One cycle so the datapath decodes the new iload; no request.
  - If readReq | writeReq: lane <= 0, go to DACCESS. Otherwise go to DONE.
- DACCESS:
  - mem_req = 1; mem_wen = writeReq.
  - Scalar: mem_addr = sdaddr, mem_wdata = sdstore.
  - Vector: mem_addr = vdaddr[lane], mem_wdata = vdstore[lane].
  - Address and data stay stable until mem_ready.
  - On mem_ready for a read: sdload <= mem_rdata (scalar) or vdload[lane] <= mem_rdata (vector).
  - Scalar, or vector with lane = THREADS-1: go to DONE on mem_ready. Otherwise lane <= lane+1 and stay.
  - readReq and writeReq both high: treat as a write.
- DONE:
  - iHit = 1 for exactly one cycle; dHit = 1 in the same cycle only if DACCESS was visited.
  - Next state is IFETCH.
- HALTED:
  - Sticky until reset; halted = 1; no mem_req.
  - iload, sdload and vdload hold their values.
- Handshake rules:
  - mem_ready is sampled only when mem_req = 1 and is ignored otherwise.
  - Zero-wait memory (mem_ready in the first request cycle) is legal.
  - A request never changes address, data or mem_wen before mem_ready.
- Output timing: sdload and vdload stay valid from capture until overwritten by a later load. Unwritten vdload lanes keep their old values.
- Latency with zero-wait memory:
  - Non-memory instruction: 3 cycles.
  - Scalar load/store: 4 cycles.
  - Vector load/store: 3+THREADS cycles.
  - Each memory wait state adds one cycle.
- Lane order: lanes are accessed strictly 0..THREADS-1; duplicate lane addresses are issued as separate accesses.

Test Plan:
- Non-memory instruction: iaddr=0x0, mem_rdata=0x20010005, zero-wait, readReq=writeReq=0 -> iload=0x20010005 after the fetch edge; iHit one pulse in cycle 3; dHit=0; mem_req low in DCHECK/DONE.
- Scalar load, 2 wait states: sdaddr=0x103 -> mem_addr=0x100, mem_wen=0 held 3 cycles; sdload=0xDEADBEEF; iHit and dHit pulse together one cycle after mem_ready.
- Vector store, THREADS=4, zero-wait: vdaddr={0x10,0x20,0x30,0x40}, vdstore={1,2,3,4} -> four consecutive writes in lane order with matching data; commit 7 cycles after the fetch starts.
- Vector load, lane 2 with 3 waits: mem_rdata per lane = 0xA0+lane -> vdload={0xA0,0xA1,0xA2,0xA3}; lane 2 address held 4 cycles.
- Halt: dhalt rises the cycle after DONE -> no further mem_req, halted=1 indefinitely, iload unchanged.
- Reset mid-vector: nRST low during lane 1 -> state IFETCH, all outputs 0 immediately (async); after release a new fetch from iaddr.
